// File: rtl/mem_stage_ctrl_if.sv
// Memory-stage bundle: execute/memory latch fields in, data-memory bus,
// writeback register and perf counters out.
interface mem_stage_ctrl_if #(parameter int CNT_W = 16);
    logic             dREN_in;
    logic             dWEN_in;
    logic [31:0]      addr_in;
    logic [31:0]      wdat_in;
    logic             WEN_in;
    logic [4:0]       wsel_in;
    logic             halt_in;
    logic             dhit;
    logic [31:0]      dmemload;
    logic             dmemREN;
    logic             dmemWEN;
    logic [31:0]      dmemaddr;
    logic [31:0]      dmemstore;
    logic             mem_stall;
    logic             wb_WEN;
    logic [4:0]       wb_wsel;
    logic [31:0]      wb_wdat;
    logic             wb_halt;
    logic [CNT_W-1:0] access_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output dREN_in, dWEN_in, addr_in, wdat_in, WEN_in, wsel_in, halt_in, dhit, dmemload,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
               wb_WEN, wb_wsel, wb_wdat, wb_halt, access_cnt, stall_cnt
    );

    modport slave (
        input  dREN_in, dWEN_in, addr_in, wdat_in, WEN_in, wsel_in, halt_in, dhit, dmemload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
               wb_WEN, wb_wsel, wb_wdat, wb_halt, access_cnt, stall_cnt
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues the data access, stalls the upstream latch
// until dhit, loads the mem/wb register, holds halt sticky, counts activity.
module mem_stage_ctrl #(parameter int CNT_W = 16) (
    input logic          CLK,
    input logic          nRST,
    mem_stage_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, HALTED} state_t;

    state_t state;
    logic   halted;
    logic   mem_op;

    assign halted = (state == HALTED);
    assign mem_op = bus.dREN_in | bus.dWEN_in;

    // Load wins when both requests are latched.
    assign bus.dmemREN   = bus.dREN_in & ~halted;
    assign bus.dmemWEN   = bus.dWEN_in & ~bus.dREN_in & ~halted;
    assign bus.dmemaddr  = bus.addr_in;
    assign bus.dmemstore = bus.wdat_in;
    assign bus.mem_stall = mem_op & ~bus.dhit & ~halted;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state          <= IDLE;
            bus.wb_WEN     <= 1'b0;
            bus.wb_wsel    <= '0;
            bus.wb_wdat    <= '0;
            bus.wb_halt    <= 1'b0;
            bus.access_cnt <= '0;
            bus.stall_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op & ~bus.dhit)
                        state <= WAIT;
                    else if (bus.halt_in)
                        state <= HALTED;
                end
                WAIT: begin
                    if (bus.dhit)
                        state <= bus.halt_in ? HALTED : IDLE;
                end
                HALTED: state <= HALTED;
                default: state <= IDLE;
            endcase

            // Once halted the wb register freezes so wb_halt stays asserted.
            if (!halted) begin
                if (bus.mem_stall) begin
                    bus.wb_WEN  <= 1'b0;
                    bus.wb_halt <= 1'b0;
                end else begin
                    bus.wb_WEN  <= bus.WEN_in;
                    bus.wb_wsel <= bus.wsel_in;
                    bus.wb_halt <= bus.halt_in;
                    bus.wb_wdat <= bus.dREN_in ? bus.dmemload : bus.addr_in;
                end
            end

            if (mem_op & bus.dhit & ~halted)
                bus.access_cnt <= bus.access_cnt + 1'b1;
            if (bus.mem_stall && bus.stall_cnt != {CNT_W{1'b1}})
                bus.stall_cnt <= bus.stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: inputs change on negedge, combinational
// outputs checked before the posedge, registers checked #1 after it.
module tb_mem_stage_ctrl;
    logic CLK = 1'b0;
    logic nRST;
    int   nchk = 0;
    int   nfail = 0;

    mem_stage_ctrl_if #(.CNT_W(16)) bus ();
    mem_stage_ctrl #(.CNT_W(16)) dut (.CLK(CLK), .nRST(nRST), .bus(bus.slave));

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        bus.dREN_in = 0; bus.dWEN_in = 0; bus.addr_in = 0; bus.wdat_in = 0;
        bus.WEN_in = 0; bus.wsel_in = 0; bus.halt_in = 0; bus.dhit = 0; bus.dmemload = 0;
    endtask

    task automatic edge_();
        @(posedge CLK); #1;
    endtask

    initial begin
        nRST = 1'b0;
        idle_in();
        #1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_wb_WEN", bus.wb_WEN, 0);
        chk("rst_wb_wsel", bus.wb_wsel, 0);
        chk("rst_wb_wdat", bus.wb_wdat, 0);
        chk("rst_wb_halt", bus.wb_halt, 0);
        chk("rst_access", bus.access_cnt, 0);
        chk("rst_stall", bus.stall_cnt, 0);
        @(negedge CLK) nRST = 1'b1;

        // ALU op passes straight through
        bus.WEN_in = 1; bus.wsel_in = 5; bus.addr_in = 32'h1234;
        #1 chk("alu_stall", bus.mem_stall, 0);
        edge_();
        chk("alu_wb_WEN", bus.wb_WEN, 1);
        chk("alu_wb_wsel", bus.wb_wsel, 5);
        chk("alu_wb_wdat", bus.wb_wdat, 32'h1234);

        // load with 3 wait cycles
        @(negedge CLK);
        idle_in();
        bus.dREN_in = 1; bus.addr_in = 32'h100; bus.WEN_in = 1; bus.wsel_in = 7;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ld_ren", bus.dmemREN, 1);
            chk("ld_addr", bus.dmemaddr, 32'h100);
            chk("ld_stall", bus.mem_stall, 1);
            edge_();
            chk("ld_bubble", bus.wb_WEN, 0);
            @(negedge CLK);
        end
        bus.dhit = 1; bus.dmemload = 32'hDEADBEEF;
        #1;
        chk("ld_ren4", bus.dmemREN, 1);
        chk("ld_stall4", bus.mem_stall, 0);
        edge_();
        chk("ld_wdat", bus.wb_wdat, 32'hDEADBEEF);
        chk("ld_wb_WEN", bus.wb_WEN, 1);
        chk("ld_wsel", bus.wb_wsel, 7);
        chk("ld_stall_cnt", bus.stall_cnt, 3);
        chk("ld_access", bus.access_cnt, 1);

        // zero-wait store
        @(negedge CLK);
        idle_in();
        bus.dWEN_in = 1; bus.wdat_in = 32'hCAFE0001; bus.addr_in = 32'h200; bus.dhit = 1;
        #1;
        chk("st_wen", bus.dmemWEN, 1);
        chk("st_ren", bus.dmemREN, 0);
        chk("st_data", bus.dmemstore, 32'hCAFE0001);
        chk("st_stall", bus.mem_stall, 0);
        edge_();
        chk("st_access", bus.access_cnt, 2);
        chk("st_wb_WEN", bus.wb_WEN, 0);
        chk("st_wdat", bus.wb_wdat, 32'h200);

        // load+store both set: load wins
        @(negedge CLK);
        bus.dREN_in = 1; bus.dWEN_in = 1; bus.dhit = 1; bus.dmemload = 32'h55;
        #1;
        chk("both_ren", bus.dmemREN, 1);
        chk("both_wen", bus.dmemWEN, 0);
        edge_();
        chk("both_access", bus.access_cnt, 3);
        chk("both_wdat", bus.wb_wdat, 32'h55);

        // stray dhit without a request is ignored
        @(negedge CLK);
        idle_in();
        bus.dhit = 1;
        edge_();
        chk("stray_access", bus.access_cnt, 3);

        // long stall to hit stall_cnt saturation
        @(negedge CLK);
        idle_in();
        bus.dREN_in = 1; bus.addr_in = 32'h400;
        repeat (65531) @(posedge CLK);
        #1 chk("sat_fffe", bus.stall_cnt, 16'hFFFE);
        repeat (3) @(posedge CLK);
        #1;
        chk("sat_ffff", bus.stall_cnt, 16'hFFFF);
        chk("sat_stall", bus.mem_stall, 1);

        // async reset mid-WAIT
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        chk("mrst_stall_cnt", bus.stall_cnt, 0);
        chk("mrst_access", bus.access_cnt, 0);
        chk("mrst_wdat", bus.wb_wdat, 0);
        chk("mrst_wsel", bus.wb_wsel, 0);
        chk("mrst_comb_stall", bus.mem_stall, 1);
        @(negedge CLK);
        idle_in();
        nRST = 1'b1;
        edge_();
        chk("post_rst_access", bus.access_cnt, 0);
        chk("post_rst_stall", bus.stall_cnt, 0);

        // halt paired with a 1-wait load: load completes first
        @(negedge CLK);
        bus.dREN_in = 1; bus.halt_in = 1; bus.WEN_in = 1; bus.wsel_in = 3; bus.addr_in = 32'h44;
        #1 chk("hl_stall", bus.mem_stall, 1);
        edge_();
        chk("hl_halt_early", bus.wb_halt, 0);
        @(negedge CLK);
        bus.dhit = 1; bus.dmemload = 32'h77;
        edge_();
        chk("hl_halt", bus.wb_halt, 1);
        chk("hl_wdat", bus.wb_wdat, 32'h77);
        chk("hl_access", bus.access_cnt, 1);

        // halted: requests suppressed, everything frozen
        @(negedge CLK);
        idle_in();
        bus.dREN_in = 1; bus.addr_in = 32'h300;
        #1;
        chk("h_ren", bus.dmemREN, 0);
        chk("h_stall", bus.mem_stall, 0);
        edge_();
        @(negedge CLK) bus.dhit = 1;
        edge_();
        chk("h_wb_halt", bus.wb_halt, 1);
        chk("h_wdat", bus.wb_wdat, 32'h77);
        chk("h_access", bus.access_cnt, 1);
        chk("h_stall_cnt", bus.stall_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
